// File: rtl/outdisplay_pkg.sv
// rtl/outdisplay_pkg.sv - mode encodings, segment constants and glyph lookup for outdisplay_mux
package outdisplay_pkg;

  localparam logic [1:0] MODE_UDEC  = 2'd0;
  localparam logic [1:0] MODE_SDEC  = 2'd1;
  localparam logic [1:0] MODE_HEX   = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} conv_state_t;

  // BCD digits needed to hold 2**w-1
  function automatic int bcd_digits(input int w);
    if (w <= 3)       return 1;
    else if (w <= 6)  return 2;
    else if (w <= 9)  return 3;
    else if (w <= 13) return 4;
    else              return 5;
  endfunction

  function automatic logic [7:0] nibble_to_seg(input logic [3:0] n);
    case (n)
      4'h0: nibble_to_seg = 8'h3F;
      4'h1: nibble_to_seg = 8'h06;
      4'h2: nibble_to_seg = 8'h5B;
      4'h3: nibble_to_seg = 8'h4F;
      4'h4: nibble_to_seg = 8'h66;
      4'h5: nibble_to_seg = 8'h6D;
      4'h6: nibble_to_seg = 8'h7D;
      4'h7: nibble_to_seg = 8'h07;
      4'h8: nibble_to_seg = 8'h7F;
      4'h9: nibble_to_seg = 8'h6F;
      4'hA: nibble_to_seg = 8'h77;
      4'hB: nibble_to_seg = 8'h7C;
      4'hC: nibble_to_seg = 8'h39;
      4'hD: nibble_to_seg = 8'h5E;
      4'hE: nibble_to_seg = 8'h79;
      default: nibble_to_seg = 8'h71;
    endcase
  endfunction

endpackage

// File: rtl/outdisp_bcd.sv
// rtl/outdisp_bcd.sv - LOAD/SHIFT/COMMIT shift-add-3 converter; hex mode reuses the timing
module outdisp_bcd
  import outdisplay_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NDIG   = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              neg,
  output logic [4*NDIG-1:0] digits
);

  localparam int SR_W = DATA_W + 4*NDIG;

  conv_state_t       state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_next;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] mag;
  logic [4*NDIG-1:0] hex_ext;
  logic              is_neg;

  assign is_neg = (mode == MODE_SDEC) && value[DATA_W-1];
  assign mag    = is_neg ? -value : value;

  always_comb begin
    sr_adj = sr;
    for (int j = 0; j < NDIG; j++) begin
      if (sr_adj[DATA_W+4*j +: 4] > 4'd4)
        sr_adj[DATA_W+4*j +: 4] = sr_adj[DATA_W+4*j +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
  end

  always_comb begin
    hex_ext = '0;
    hex_ext[DATA_W-1:0] = value;
  end

  assign digits = (mode == MODE_HEX) ? hex_ext : sr[SR_W-1 -: 4*NDIG];

  // a start in any state restarts from LOAD, discarding the partial result
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= ST_LOAD;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_LOAD: begin
            sr    <= SR_W'(mag);
            neg   <= is_neg;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            sr  <= sr_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(DATA_W - 1)) begin
              state <= ST_COMMIT;
              done  <= 1'b1;
            end
          end
          ST_COMMIT: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/outdisplay_mux.sv
// rtl/outdisplay_mux.sv - value register, digit buffer and multiplexed seven-segment scan
// OUTDISP_LZB_EN: blank leading zeros and float the minus sign next to the top shown digit
module outdisplay_mux
  import outdisplay_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              oi,
  input  logic [DATA_W-1:0] bus,
  input  logic [1:0]        mode,
  output logic [DIGITS-1:0] cc,
  output logic [7:0]        seg,
  output logic [DATA_W-1:0] value,
  output logic              busy
);

  localparam int NDIG  = bcd_digits(DATA_W);
  localparam int PAD   = (NDIG > DIGITS) ? NDIG : DIGITS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SEL_W = $clog2(DIGITS);

  logic [1:0]        mode_q;
  logic              start;
  logic              done;
  logic              neg;
  logic [4*NDIG-1:0] digits;
  logic [4*PAD-1:0]  dpad;
  logic [7:0]        fmt  [DIGITS];
  logic [7:0]        dbuf [DIGITS];
  logic [PRE_W-1:0]  pre;
  logic [SEL_W-1:0]  scan;
  logic [SEL_W-1:0]  sel;
  logic              step;
  logic              ovf;
  int                nsig;

  // a mode change is only acted on once the converter is idle
  assign start = oi || (!busy && (mode != mode_q));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      value  <= '0;
      mode_q <= MODE_UDEC;
    end else if (start) begin
      mode_q <= mode;
      if (oi) value <= bus;
    end
  end

  outdisp_bcd #(
    .DATA_W (DATA_W),
    .NDIG   (NDIG)
  ) u_bcd (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .value  (value),
    .mode   (mode_q),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .digits (digits)
  );

  always_comb begin
    dpad = '0;
    dpad[4*NDIG-1:0] = digits;
    nsig = 1;
    for (int j = 0; j < NDIG; j++) begin
      if (digits[4*j +: 4] != 4'd0) nsig = j + 1;
    end
    ovf = (nsig + (neg ? 1 : 0)) > DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef OUTDISP_LZB_EN
      if (i < nsig)                fmt[i] = nibble_to_seg(dpad[4*i +: 4]);
      else if (neg && (i == nsig)) fmt[i] = SEG_MINUS;
      else                         fmt[i] = SEG_BLANK;
`else
      if (neg && (i == DIGITS - 1)) fmt[i] = SEG_MINUS;
      else                          fmt[i] = nibble_to_seg(dpad[4*i +: 4]);
`endif
      if (ovf)                  fmt[i] = SEG_MINUS;
      if (mode_q == MODE_BLANK) fmt[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DIGITS; i++) dbuf[i] <= SEG_BLANK;
    end else if (done && !start) begin
      dbuf <= fmt;
    end
  end

  assign step = (pre == PRE_W'(PRESCALE - 1));
  assign sel  = !step ? scan :
                (scan == SEL_W'(DIGITS - 1)) ? '0 : scan + SEL_W'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre  <= '0;
      scan <= '0;
      cc   <= ~DIGITS'(1);
      seg  <= SEG_BLANK;
    end else begin
      pre  <= step ? '0 : pre + PRE_W'(1);
      scan <= sel;
      cc   <= ~(DIGITS'(1) << sel);
      seg  <= dbuf[sel];
    end
  end

endmodule

// File: tb/tb_outdisplay_mux.sv
// tb/tb_outdisplay_mux.sv - scoreboard bench for outdisplay_mux, with or without OUTDISP_LZB_EN
module tb_outdisplay_mux;

  logic       clk = 1'b0;
  logic       clr;
  logic       oi;
  logic [7:0] bus;
  logic [1:0] mode;

  logic [3:0] cc4, cc3;
  logic [1:0] cc2;
  logic [7:0] seg4, seg2, seg3;
  logic [7:0] val4, val2, val3;
  logic       busy4, busy2, busy3;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] e4;
    logic [15:0] e2;
  } exp_t;
  exp_t sb[$];

  localparam logic [7:0] GLYPH [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk = ~clk;

  outdisplay_mux u_dut (
    .clk(clk), .clr(clr), .oi(oi), .bus(bus), .mode(mode),
    .cc(cc4), .seg(seg4), .value(val4), .busy(busy4)
  );

  outdisplay_mux #(.DIGITS(2)) u_dut2 (
    .clk(clk), .clr(clr), .oi(oi), .bus(bus), .mode(mode),
    .cc(cc2), .seg(seg2), .value(val2), .busy(busy2)
  );

  outdisplay_mux #(.PRESCALE(3)) u_dut3 (
    .clk(clk), .clr(clr), .oi(oi), .bus(bus), .mode(mode),
    .cc(cc3), .seg(seg3), .value(val3), .busy(busy3)
  );

  bit mon_en = 1'b0;
  bit saw12  = 1'b0;
  always @(negedge clk) begin
    if (mon_en && (((cc4 == 4'b1110) && (seg4 == 8'h5B)) || ((cc4 == 4'b1101) && (seg4 == 8'h06))))
      saw12 = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] model(input logic [7:0] v, input logic [1:0] md, input int nd);
    logic [47:0] r;
    int  mag, base, nsig;
    int  d [6];
    bit  neg;
    r = '0;
    if (md == 2'd3) return r;
    neg  = (md == 2'd1) && v[7];
    mag  = neg ? 256 - int'(v) : int'(v);
    base = (md == 2'd2) ? 16 : 10;
    nsig = 1;
    for (int i = 0; i < 6; i++) begin
      d[i] = mag % base;
      mag  = mag / base;
      if (d[i] != 0) nsig = i + 1;
    end
    if (nsig + int'(neg) > nd) begin
      for (int i = 0; i < nd; i++) r[8*i +: 8] = 8'h40;
      return r;
    end
    for (int i = 0; i < nd; i++) begin
`ifdef OUTDISP_LZB_EN
      if (i < nsig)             r[8*i +: 8] = GLYPH[d[i]];
      else if (neg && i == nsig) r[8*i +: 8] = 8'h40;
      else                      r[8*i +: 8] = 8'h00;
`else
      if (neg && i == nd - 1) r[8*i +: 8] = 8'h40;
      else                    r[8*i +: 8] = GLYPH[d[i]];
`endif
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] v, input logic [1:0] md);
    logic [47:0] m4, m2;
    exp_t e;
    m4 = model(v, md, 4);
    m2 = model(v, md, 2);
    e.e4 = m4[31:0];
    e.e2 = m2[15:0];
    sb.push_back(e);
  endtask

  task automatic pulse_oi(input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    bus  = d;
    mode = m;
    oi   = 1'b1;
    @(posedge clk);
    #1 oi = 1'b0;
    check("value_load", val4, d);
  endtask

  task automatic change_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy4) n++;
      else break;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy4) break;
    end
  endtask

  task automatic read_one(input int i, output logic [7:0] s);
    logic [3:0] tgt;
    s   = 'x;
    tgt = ~(4'b0001 << i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cc4 === tgt) begin
        s = seg4;
        break;
      end
    end
  endtask

  task automatic read_digits(output logic [31:0] s4, output logic [15:0] s2);
    logic [3:0] tgt4;
    logic [1:0] tgt2;
    s4 = 'x;
    s2 = 'x;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tgt4 = ~(4'b0001 << i);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (cc4 === tgt4) begin
          s4[8*i +: 8] = seg4;
          break;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      tgt2 = ~(2'b01 << i);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (cc2 === tgt2) begin
          s2[8*i +: 8] = seg2;
          break;
        end
      end
    end
  endtask

  task automatic check_result(input string tag);
    exp_t        e;
    logic [31:0] s4;
    logic [15:0] s2;
    e = sb.pop_front();
    read_digits(s4, s2);
    check({tag, "_d4"}, s4, e.e4);
    check({tag, "_d2"}, s2, e.e2);
  endtask

  initial begin
    int          n;
    logic [7:0]  mid;
    logic [3:0]  prev3;
    logic [3:0]  tgt;
    logic [31:0] s4;
    logic [15:0] s2;
    logic [47:0] m4;

    clr = 1'b1; oi = 1'b1; bus = 8'h5A; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", val4, 8'h00);
    check("rst_busy", busy4, 1'b0);
    check("rst_cc", cc4, 4'b1110);
    check("rst_seg", seg4, 8'h00);
    check("rst_cc_pre3", cc3, 4'b1110);
    @(negedge clk);
    oi = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1 check("scan_first_step", cc4, 4'b1101);

    sb_push(8'd7, 2'd0);
    pulse_oi(8'd7, 2'd0);
    busy_len(n);
    check("s1_busy_len", n, 10);
    check_result("s1_udec7");

    m4 = model(8'd7, 2'd0, 4);
    sb_push(8'h80, 2'd1);
    pulse_oi(8'h80, 2'd1);
    read_one(0, mid);
    check("s2_hold_prev", mid, m4[7:0]);
    check("s2_busy_mid", busy4, 1'b1);
    wait_idle();
    check("s2_idle", busy4, 1'b0);
    check_result("s2_sdec_m128");

    sb_push(8'hAB, 2'd2);
    pulse_oi(8'hAB, 2'd2);
    busy_len(n);
    check("s3_busy_len", n, 10);
    check_result("s3_hexAB");

    sb_push(8'hAB, 2'd0);
    change_mode(2'd0);
    busy_len(n);
    check("s4_modechg_busy_len", n, 10);
    check_result("s4_udec171");

    sb_push(8'hAB, 2'd3);
    change_mode(2'd3);
    wait_idle();
    check_result("s5_blank");

    sb_push(8'hFF, 2'd1);
    pulse_oi(8'hFF, 2'd1);
    wait_idle();
    check_result("s6_sdec_m1");

    sb_push(8'd200, 2'd0);
    pulse_oi(8'd200, 2'd0);
    busy_len(n);
    check("s7_busy_len", n, 10);
    check_result("s7_udec200");

    mon_en = 1'b1;
    saw12  = 1'b0;
    pulse_oi(8'd12, 2'd0);
    repeat (3) @(posedge clk);
    sb_push(8'd99, 2'd0);
    pulse_oi(8'd99, 2'd0);
    busy_len(n);
    check("s8_restart_busy_len", n, 10);
    check_result("s8_udec99");
    mon_en = 1'b0;
    check("s8_no_12_shown", saw12, 1'b0);

    prev3 = cc3;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((cc3 == 4'b1110) && (prev3 != 4'b1110)) break;
      prev3 = cc3;
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        if ((k != 0) || (c != 0)) @(negedge clk);
        tgt = ~(4'b0001 << k);
        check($sformatf("s9_cc_step%0d_cyc%0d", k, c), cc3, tgt);
      end
    end
    @(negedge clk);
    check("s9_cc_wrap", cc3, 4'b1110);

    pulse_oi(8'd5, 2'd0);
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("s10_busy_abort", busy4, 1'b0);
    check("s10_busy3_abort", busy3, 1'b0);
    check("s10_value_clr", val4, 8'h00);
    check("s10_cc3_clr", cc3, 4'b1110);
    check("s10_seg3_clr", seg3, 8'h00);
    oi  = 1'b1;
    bus = 8'h33;
    repeat (2) @(posedge clk);
    #1 check("s10_oi_ignored", val4, 8'h00);
    @(negedge clk);
    oi  = 1'b0;
    clr = 1'b0;
    repeat (14) @(negedge clk);
    check("s10_no_commit_busy", busy4, 1'b0);
    read_digits(s4, s2);
    check("s10_blank_d4", s4, 32'h0);
    check("s10_blank_d2", s2, 16'h0);

    @(negedge clk);
    clr = 1'b1;
    oi  = 1'b1;
    bus = 8'd3;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    sb_push(8'd3, 2'd0);
    @(posedge clk);
    #1 oi = 1'b0;
    check("s11_first_load", val4, 8'd3);
    check("s11_busy", busy4, 1'b1);
    wait_idle();
    check_result("s11_udec3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
